// File: rtl/burst_sched_if.sv
// Signal bundle between the interrupter front end (master) and burst_sched (slave).
interface burst_sched_if #(
  parameter int TW = 16
);
  logic          en;
  logic [TW-1:0] on_us;
  logic [TW-1:0] per_us;
  logic          gen;
  logic          fault;
  logic          burst;
  logic          busy;
  logic          clamped;
  logic          locked;
  logic [15:0]   burst_cnt;

  modport master (
    output en, on_us, per_us, gen, fault,
    input  burst, busy, clamped, locked, burst_cnt
  );

  modport slave (
    input  en, on_us, per_us, gen, fault,
    output burst, busy, clamped, locked, burst_cnt
  );
endinterface

// File: rtl/burst_sched.sv
// DRSSTC burst scheduler: clamps the on-time/period request per burst and produces a
// burst window that closes on a feedback rising edge, with minimum off time and fault lockout.
module burst_sched #(
  parameter int CLK_MHZ     = 100,
  parameter int TW          = 16,
  parameter int MAX_ON_US   = 200,
  parameter int MIN_PER_US  = 1000,
  parameter int MIN_OFF_US  = 500,
  parameter int TAIL_MAX_US = 10,
  parameter int LOCKOUT_US  = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  burst_sched_if.slave bus
);
  localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam int LW = (LOCKOUT_US > 0) ? $clog2(LOCKOUT_US + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_MHZ - 1);
  localparam logic [TW-1:0] MAX_ON     = TW'(MAX_ON_US);
  localparam logic [TW-1:0] MIN_PER    = TW'(MIN_PER_US);
  localparam logic [TW-1:0] MIN_OFF    = TW'(MIN_OFF_US);
  localparam logic [TW-1:0] TAIL_MAX   = TW'(TAIL_MAX_US);
  localparam logic [LW-1:0] LOCK_END   = LW'(LOCKOUT_US);

  typedef enum logic [2:0] {S_IDLE, S_ON, S_TAIL, S_OFF, S_FAULT} state_t;

  state_t        state_reg, state_next;
  logic          gen_s1, gen_s, gen_s_d, gen_rise;
  logic [PW-1:0] presc;
  logic          tick;
  logic [TW-1:0] per_cnt, off_cnt, tail_cnt, on_l, per_l;
  logic [LW-1:0] lock_cnt;
  logic [TW-1:0] per_inc, off_inc, tail_inc;
  logic [LW-1:0] lock_inc;
  logic [TW-1:0] on_eff, cfg_on, cfg_per;
  logic          cfg_clamp;
  logic          on_done, tail_done, off_done, lock_done;
  logic          start_burst, state_chg, burst_end;
  logic          burst_reg, busy_reg, clamped_reg, locked_reg;
  logic [15:0]   burst_cnt_reg;

  // gen is free-running from the coil current transformer, so it is synchronised first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_s1   <= 1'b0;
      gen_s    <= 1'b0;
      gen_s_d  <= 1'b0;
      gen_rise <= 1'b0;
    end else begin
      gen_s1   <= bus.gen;
      gen_s    <= gen_s1;
      gen_s_d  <= gen_s;
      gen_rise <= gen_s & ~gen_s_d;
    end
  end

  assign tick     = (presc == PRESC_LAST);
  assign per_inc  = (&per_cnt)  ? per_cnt  : per_cnt  + TW'(tick);
  assign off_inc  = (&off_cnt)  ? off_cnt  : off_cnt  + TW'(tick);
  assign tail_inc = (&tail_cnt) ? tail_cnt : tail_cnt + TW'(tick);
  assign lock_inc = (&lock_cnt) ? lock_cnt : lock_cnt + LW'(tick);

  assign on_eff    = (bus.on_us == '0) ? TW'(1) : bus.on_us;
  assign cfg_on    = (on_eff > MAX_ON) ? MAX_ON : on_eff;
  assign cfg_per   = (bus.per_us < MIN_PER) ? MIN_PER : bus.per_us;
  assign cfg_clamp = (bus.on_us > MAX_ON) | (bus.per_us < MIN_PER);

  // Thresholds look at the post-tick counter value so each transition lands on the tick edge.
  assign on_done   = (per_inc >= on_l);
  assign tail_done = gen_rise | (tail_inc >= TAIL_MAX);
  assign off_done  = (per_inc >= per_l) & (off_inc >= MIN_OFF);
  assign lock_done = (lock_inc >= LOCK_END) & ~bus.fault & ~bus.en;

  always_comb begin
    state_next = state_reg;
    if (bus.fault && state_reg != S_FAULT) begin
      state_next = S_FAULT;
    end else begin
      case (state_reg)
        S_IDLE:  if (bus.en)    state_next = S_ON;
        S_ON:    if (on_done)   state_next = S_TAIL;
        S_TAIL:  if (tail_done) state_next = S_OFF;
        S_OFF:   if (off_done)  state_next = bus.en ? S_ON : S_IDLE;
        S_FAULT: if (lock_done) state_next = S_IDLE;
        default:                state_next = S_IDLE;
      endcase
    end
  end

  assign start_burst = (state_next == S_ON) && (state_reg != S_ON);
  assign state_chg   = (state_next != state_reg);
  assign burst_end   = ((state_reg == S_ON) || (state_reg == S_TAIL)) && (state_next == S_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      burst_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      locked_reg    <= 1'b0;
      clamped_reg   <= 1'b0;
      burst_cnt_reg <= '0;
      presc         <= '0;
      per_cnt       <= '0;
      off_cnt       <= '0;
      tail_cnt      <= '0;
      lock_cnt      <= '0;
      on_l          <= '0;
      per_l         <= '0;
    end else begin
      state_reg  <= state_next;
      burst_reg  <= (state_next == S_ON) || (state_next == S_TAIL);
      busy_reg   <= (state_next != S_IDLE);
      locked_reg <= (state_next == S_FAULT);
      presc      <= (state_chg || tick) ? '0 : presc + PW'(1);

      if (start_burst) begin
        on_l        <= cfg_on;
        per_l       <= cfg_per;
        clamped_reg <= cfg_clamp;
        per_cnt     <= '0;
      end else begin
        per_cnt <= per_inc;
      end

      off_cnt  <= (state_reg == S_OFF  && state_next == S_OFF)  ? off_inc  : '0;
      tail_cnt <= (state_reg == S_TAIL && state_next == S_TAIL) ? tail_inc : '0;
      // Any cycle with fault high restarts the lockout interval.
      lock_cnt <= (state_reg == S_FAULT && state_next == S_FAULT && !bus.fault) ? lock_inc : '0;

      if (burst_end)
        burst_cnt_reg <= burst_cnt_reg + 16'd1;
    end
  end

  assign bus.burst     = burst_reg;
  assign bus.busy      = busy_reg;
  assign bus.clamped   = clamped_reg;
  assign bus.locked    = locked_reg;
  assign bus.burst_cnt = burst_cnt_reg;
endmodule

// File: doc/burst_sched.md
Name: burst_sched

Overview:
- Burst scheduler for the DRSSTC interrupter path. Turns the operator's on-time/period request into a safe `burst` enable window that gates the driver.
- Latches and clamps configuration per burst, then counts time in microseconds.
- Ends each burst on a feedback (`gen`) rising edge so the bridge stops at a current zero crossing.
- Enforces a minimum off time and a fault lockout.

Parameters:
- CLK_MHZ, 100, clock frequency in MHz; the microsecond prescaler divides by this value.
- TW, 16, width of the µs timing inputs and counters.
- MAX_ON_US, 200, upper clamp for on time.
- MIN_PER_US, 1000, lower clamp for period.
- MIN_OFF_US, 500, minimum gap from burst end to the next burst start.
- TAIL_MAX_US, 10, hard limit on waiting for the closing `gen` edge.
- LOCKOUT_US, 50000, minimum time spent in FAULT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run request, level, synchronous to clk
- on_us  in  TW  requested on time in µs
- per_us  in  TW  requested burst period in µs
- gen  in  1  raw feedback square wave, asynchronous
- fault  in  1  overcurrent/fault, level, synchronous to clk
- burst  out  1  burst enable window, registered
- busy  out  1  high in any state except IDLE
- clamped  out  1  set when the current burst's on_us or per_us was clamped
- locked  out  1  high while in FAULT
- burst_cnt  out  16  number of completed bursts, wraps 0xFFFF→0

Behaviour:
- **Reset.** rst_n low asynchronously sets:
  - state=IDLE
  - burst, busy, clamped and locked to 0
  - burst_cnt=0
  - all counters and synchroniser flops to 0.
  - Reset mid-burst drops `burst` immediately (asynchronously).
- **gen conditioning.** Two-flop synchroniser, then an edge register. gen_rise = gen_s & ~gen_s_d. gen_rise asserts 3 clk after a gen rising edge.
- **µs tick.** Prescaler counts 0..CLK_MHZ-1 and pulses `tick` on the terminal count. It clears on every state change, so each interval is exact to ±0 tick from state entry.
- **Latch at burst start (IDLE→ON and OFF→ON):**
  - on_l = min(on_us, MAX_ON_US)
  - per_l = max(per_us, MIN_PER_US)
  - clamped = (on_us>MAX_ON_US) | (per_us<MIN_PER_US)
  - on_us=0 is treated as 1.
- **Counters.**
  - per_cnt counts ticks from burst start and saturates at all-ones.
  - off_cnt counts ticks from burst end and saturates.
  - tail_cnt counts ticks inside TAIL.
- **IDLE.** burst=0. If en=1 and fault=0: latch config, go to ON. burst=1 on the next clk edge (1 clk latency from en sampled high). The first burst starts without waiting for gen (coil not ringing).
- **ON.** burst=1. When per_cnt reaches on_l, go to TAIL.
- **TAIL.** burst=1 until either:
  - gen_rise, or
  - tail_cnt reaches TAIL_MAX_US (forced stop).

  Either event goes to OFF; burst=0 on the following edge. burst_cnt increments on the ON/TAIL→OFF transition only.
- **OFF.** burst=0. Next burst starts when per_cnt ≥ per_l AND off_cnt ≥ MIN_OFF_US:
  - en=1: relatch config and go to ON.
  - en=0: go to IDLE.
- **en dropped.** en=0 during ON does not shorten the burst. The burst runs to completion, then returns to IDLE from OFF.
- **FAULT.**
  - Entry: fault=1 in any state except FAULT goes to FAULT on the next edge; burst=0 on that same edge. Fault has priority over every other transition in the same cycle.
  - A fault-aborted burst does not increment burst_cnt.
  - While in FAULT: locked=1. The lockout counter runs LOCKOUT_US and restarts whenever fault is high.
  - Exit: after expiry with fault=0 AND en=0, go to IDLE. This forces an operator re-arm.
- **Config changes.** Changes to on_us/per_us mid-burst have no effect until the next latch.
- **busy.** busy = (state≠IDLE).

Test Plan:
- **Basic burst.** on_us=50, per_us=2000, gen 200 kHz, en=1 for 3 bursts → burst rises 1 clk after en. Each burst ends 3–4 clk after the first gen rise following 50 µs. Burst starts are 2000 µs apart; burst_cnt=3; clamped=0.
- **Clamping.** on_us=500, per_us=100 → on_l=200, per_l=1000, clamped=1. Burst ≈200 µs+tail, repeating every 1000 µs.
- **Tail timeout.** gen held low, on_us=20 → burst width exactly (20+TAIL_MAX_US)×CLK_MHZ clk = 3000 clk; burst_cnt increments.
- **Minimum off time.** on_us=200, per_us=1000, gen held low so each burst ends on the tail timeout (burst end at 210 µs) → next start at 1000 µs. Repeat with the MIN_OFF_US parameter overridden to 900 → next start at 1110 µs (210+900), i.e. the off-time bound is met.
- **Fault mid-burst.**
  - fault pulsed at 30 µs into ON → burst=0 next clk, locked=1, burst_cnt unchanged.
  - With en still high, locked stays 1 past LOCKOUT_US.
  - Drop en → IDLE 1 clk later.
- **Async reset.** rst_n low during TAIL → burst=0 with no clk edge. After release with en=1, a new burst starts and burst_cnt=0.
